sine_table_loader: RTL

Owns the 16K x 15-bit quarter-wave sine table RAM that feeds the waveform generator stage. It replaces the boot-time ROM image with a RAM that a host writes after reset. It sequences the load, blocks further writes once the table is full, and masks table reads until a complete table is present. It serves one registered read per clock to the waveform pipeline, occupying the table-lookup pipeline slot.

---
 rtl/sine_table_loader_pkg.sv | 14 +
 rtl/sine_table_loader_ram.sv | 32 +++
 rtl/sine_table_loader.sv | 98 +++++++++
 3 files changed

// File: rtl/sine_table_loader_pkg.sv
// Shared definitions for the quarter-wave sine table and its loader.
package sine_table_loader_pkg;

  localparam int SINE_TABLE_ADDRESS_WIDTH = 14;
  localparam int SINE_TABLE_DATA_WIDTH    = 15;
  localparam int SINE_TABLE_CHECKSUM_WIDTH = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } SineTableState_t;

endpackage

// File: rtl/sine_table_loader_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Storage has no reset so it maps onto block RAM.
module sine_table_ram #(
  parameter int ADDRESS_WIDTH = 14,
  parameter int DATA_WIDTH    = 15
) (
  input  logic                     i_Clock,
  input  logic                     i_WriteEnable,
  input  logic [ADDRESS_WIDTH-1:0] i_WriteAddress,
  input  logic [DATA_WIDTH-1:0]    i_WriteData,
  input  logic [ADDRESS_WIDTH-1:0] i_ReadAddress,
  output logic [DATA_WIDTH-1:0]    o_ReadData
);

  logic [DATA_WIDTH-1:0] r_Memory [0:(2**ADDRESS_WIDTH)-1];
  logic [DATA_WIDTH-1:0] r_ReadData;

  // Write port: store the sample when enabled.
  always_ff @(posedge i_Clock) begin
    if (i_WriteEnable) begin
      r_Memory[i_WriteAddress] <= i_WriteData;
    end
  end

  // Read port: one-cycle registered read every clock.
  always_ff @(posedge i_Clock) begin
    r_ReadData <= r_Memory[i_ReadAddress];
  end

  assign o_ReadData = r_ReadData;

endmodule

// File: rtl/sine_table_loader.sv
// Quarter-wave sine table loader: sequences a host load into the table RAM,
// tracks count and checksum, and masks lookups until a full table is present.
//
// Write handshake: a sample transfers on a rising clock edge exactly when
// i_WriteValid and o_WriteReady are both high. o_WriteReady is high only in
// LOAD and drops combinationally while i_LoadStart is asserted, so a restart
// always wins over a concurrent write. i_WriteValid may drop at any time and
// the load simply waits.
module sine_table_loader
  import sine_table_loader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = SINE_TABLE_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = SINE_TABLE_DATA_WIDTH
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset_n,
  input  logic                     i_LoadStart,
  input  logic                     i_WriteValid,
  input  logic [DATA_WIDTH-1:0]    i_WriteData,
  output logic                     o_WriteReady,
  output logic                     o_Loading,
  output logic                     o_TableReady,
  output logic [ADDRESS_WIDTH:0]   o_WordCount,
  output logic [15:0]              o_Checksum,
  input  logic [ADDRESS_WIDTH-1:0] i_ReadAddress,
  output logic [DATA_WIDTH-1:0]    o_ReadData
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDRESS = '1;
  localparam logic [ADDRESS_WIDTH-1:0] ADDRESS_ONE  = ADDRESS_WIDTH'(1);
  localparam logic [ADDRESS_WIDTH:0]   COUNT_ONE    = (ADDRESS_WIDTH+1)'(1);

  SineTableState_t           r_State;
  logic [ADDRESS_WIDTH-1:0]  r_WriteAddress;
  logic [ADDRESS_WIDTH:0]    r_WordCount;
  logic [15:0]               r_Checksum;
  logic                      r_ReadGate;

  logic                      w_Accept;
  logic                      w_LastAddress;
  logic [DATA_WIDTH-1:0]     w_RamData;

  assign o_WriteReady  = (r_State == LOAD) && !i_LoadStart;
  assign w_Accept      = i_WriteValid && o_WriteReady;
  assign w_LastAddress = (r_WriteAddress == LAST_ADDRESS);

  // Load controller: restart on i_LoadStart from any state, advance on accepts,
  // and finish once the last table address has been written.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_State        <= EMPTY;
      r_WriteAddress <= '0;
      r_WordCount    <= '0;
      r_Checksum     <= '0;
    end else if (i_LoadStart) begin
      r_State        <= LOAD;
      r_WriteAddress <= '0;
      r_WordCount    <= '0;
      r_Checksum     <= '0;
    end else if (w_Accept) begin
      r_WriteAddress <= r_WriteAddress + ADDRESS_ONE;
      r_WordCount    <= r_WordCount + COUNT_ONE;
      r_Checksum     <= r_Checksum + 16'(i_WriteData);
      if (w_LastAddress) begin
        r_State <= READY;
      end
    end
  end

  // Read gate: table-ready sampled alongside the lookup address, so each read
  // result is qualified by the state at the time its address was taken.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_ReadGate <= 1'b0;
    end else begin
      r_ReadGate <= (r_State == READY);
    end
  end

  sine_table_ram #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_ram (
    .i_Clock        (i_Clock),
    .i_WriteEnable  (w_Accept),
    .i_WriteAddress (r_WriteAddress),
    .i_WriteData    (i_WriteData),
    .i_ReadAddress  (i_ReadAddress),
    .o_ReadData     (w_RamData)
  );

  assign o_Loading    = (r_State == LOAD);
  assign o_TableReady = (r_State == READY);
  assign o_WordCount  = r_WordCount;
  assign o_Checksum   = r_Checksum;
  assign o_ReadData   = r_ReadGate ? w_RamData : '0;

endmodule
